// File: rtl/riscv_trace_pkg.sv
// Shared types and field-sequencing helpers for the commit-trace byte serializer.
package riscv_trace_pkg;

    typedef enum logic [1:0] {
        TRACE_CTRL  = 2'b00,
        TRACE_REG   = 2'b01,
        TRACE_LOAD  = 2'b10,
        TRACE_STORE = 2'b11
    } trace_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_RD, ST_PC, ST_INSTR, ST_VAL, ST_ADDR, ST_SDATA
    } trace_state_e;

    typedef struct packed {
        trace_kind_e kind;
        logic        compressed;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] rdval;
        logic [63:0] memaddr;
        logic [63:0] sdata;
    } trace_rec_t;

    localparam int PC_BYTES   = 8;
    localparam int VAL_BYTES  = 8;
    localparam int ADDR_BYTES = 8;

    function automatic logic has_val(input trace_rec_t r);
        return (r.kind == TRACE_REG) || ((r.kind == TRACE_LOAD) && (r.rd != 5'd0));
    endfunction

    function automatic logic has_addr(input trace_rec_t r);
        return (r.kind == TRACE_LOAD) || (r.kind == TRACE_STORE);
    endfunction

    // Index of the final byte of the given field for this record.
    function automatic logic [2:0] field_last(input trace_state_e st, input trace_rec_t r);
        logic [2:0] last;
        last = 3'd0;
        case (st)
            ST_PC:    last = 3'(PC_BYTES - 1);
            ST_INSTR: last = r.compressed ? 3'd1 : 3'd3;
            ST_VAL:   last = 3'(VAL_BYTES - 1);
            ST_ADDR:  last = 3'(ADDR_BYTES - 1);
            ST_SDATA: begin
                case (r.funct3[1:0])
                    2'b00:   last = 3'd0;
                    2'b01:   last = 3'd1;
                    2'b10:   last = 3'd3;
                    default: last = 3'd7;
                endcase
            end
            default:  last = 3'd0;
        endcase
        return last;
    endfunction

    // Field following st; ST_IDLE marks end of packet.
    function automatic trace_state_e field_next(input trace_state_e st, input trace_rec_t r);
        trace_state_e nxt;
        nxt = ST_IDLE;
        case (st)
            ST_HDR:   nxt = ST_RD;
            ST_RD:    nxt = ST_PC;
            ST_PC:    nxt = ST_INSTR;
            ST_INSTR: nxt = has_val(r) ? ST_VAL : (has_addr(r) ? ST_ADDR : ST_IDLE);
            ST_VAL:   nxt = has_addr(r) ? ST_ADDR : ST_IDLE;
            ST_ADDR:  nxt = (r.kind == TRACE_STORE) ? ST_SDATA : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Synchronous record FIFO; head entry is presented combinationally until popped.
module riscv_trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_rec_t               din,
    input  logic                     pop,
    output trace_rec_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    // A pop in the same cycle never makes room for a push into a full FIFO.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/riscv_commit_trace_tx.sv
// Commit-trace producer: buffers retired-instruction records and streams them as byte packets.
module riscv_commit_trace_tx
    import riscv_trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic              i_riscv_trace_clk,
    input  logic              i_riscv_trace_rst_n,
    input  logic              i_riscv_trace_valid,
    input  logic [1:0]        i_riscv_trace_kind,
    input  logic              i_riscv_trace_compressed,
    input  logic [2:0]        i_riscv_trace_funct3,
    input  logic [4:0]        i_riscv_trace_rd,
    input  logic [63:0]       i_riscv_trace_pc,
    input  logic [31:0]       i_riscv_trace_instr,
    input  logic [63:0]       i_riscv_trace_rdval,
    input  logic [63:0]       i_riscv_trace_memaddr,
    input  logic [63:0]       i_riscv_trace_store,
    output logic [7:0]        o_riscv_trace_byte,
    output logic              o_riscv_trace_byte_valid,
    input  logic              i_riscv_trace_byte_ready,
    output logic              o_riscv_trace_full,
    output logic [DROP_W-1:0] o_riscv_trace_drops,
    output logic              o_riscv_trace_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    trace_state_e      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DROP_W-1:0] drops_q, drops_d;
    trace_rec_t        rec_in, head;
    logic              fifo_full, fifo_empty, pop;
    logic [CW-1:0]     fifo_count;
    logic [5:0]        bit_idx;
    trace_state_e      nxt_field;

    always_comb begin
        rec_in.kind       = trace_kind_e'(i_riscv_trace_kind);
        rec_in.compressed = i_riscv_trace_compressed;
        rec_in.funct3     = i_riscv_trace_funct3;
        rec_in.rd         = i_riscv_trace_rd;
        rec_in.pc         = i_riscv_trace_pc;
        rec_in.instr      = i_riscv_trace_instr;
        rec_in.rdval      = i_riscv_trace_rdval;
        rec_in.memaddr    = i_riscv_trace_memaddr;
        rec_in.sdata      = i_riscv_trace_store;
    end

    riscv_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_riscv_trace_clk),
        .rst_n (i_riscv_trace_rst_n),
        .push  (i_riscv_trace_valid),
        .din   (rec_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        nxt_field = field_next(state_q, head);
        if (state_q == ST_IDLE) begin
            cnt_d = 3'd0;
            if (!fifo_empty) state_d = ST_HDR;
        end else if (i_riscv_trace_byte_ready) begin
            if (cnt_q == field_last(state_q, head)) begin
                cnt_d = 3'd0;
                if (nxt_field == ST_IDLE) begin
                    // Packet done: chain straight into the next queued record.
                    pop     = 1'b1;
                    state_d = (fifo_count > CW'(1)) ? ST_HDR : ST_IDLE;
                end else begin
                    state_d = nxt_field;
                end
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        drops_d = drops_q;
        if (i_riscv_trace_valid && fifo_full && (drops_q != {DROP_W{1'b1}}))
            drops_d = drops_q + 1'b1;
    end

    always_ff @(posedge i_riscv_trace_clk or negedge i_riscv_trace_rst_n) begin
        if (!i_riscv_trace_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drops_q <= drops_d;
        end
    end

    assign bit_idx = {cnt_q, 3'b000};

    always_comb begin
        o_riscv_trace_byte = 8'h00;
        case (state_q)
            ST_HDR:   o_riscv_trace_byte = {head.kind, head.compressed, head.funct3, 2'b00};
            ST_RD:    o_riscv_trace_byte = {3'b000, head.rd};
            ST_PC:    o_riscv_trace_byte = head.pc[bit_idx +: 8];
            ST_INSTR: o_riscv_trace_byte = head.instr[bit_idx[4:0] +: 8];
            ST_VAL:   o_riscv_trace_byte = head.rdval[bit_idx +: 8];
            ST_ADDR:  o_riscv_trace_byte = head.memaddr[bit_idx +: 8];
            ST_SDATA: o_riscv_trace_byte = head.sdata[bit_idx +: 8];
            default:  o_riscv_trace_byte = 8'h00;
        endcase
    end

    assign o_riscv_trace_byte_valid = (state_q != ST_IDLE);
    assign o_riscv_trace_full       = fifo_full;
    assign o_riscv_trace_drops      = drops_q;
    assign o_riscv_trace_busy       = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: doc/riscv_commit_trace_tx.md
Name: riscv_commit_trace_tx

Overview:
- Hardware producer of the per-instruction commit trace: captures one retired-instruction record per cycle from the writeback stage.
- Buffers records in a small FIFO and serializes each into a byte-packet stream (valid/ready) toward the debug UART/trace port.
- An off-chip host reconstructs the same "pc (instr) xN value mem addr data" lines the simulation log prints, so silicon and RTL traces can be diffed.

Parameters:
- FIFO_DEPTH, 4, record FIFO entries (power of 2, ≥2)
- DROP_W, 16, width of saturating drop counter

Ports:
- i_riscv_trace_clk  in  1  core clock
- i_riscv_trace_rst_n  in  1  asynchronous active-low reset
- i_riscv_trace_valid  in  1  a record is presented this cycle (retired, not stalled)
- i_riscv_trace_kind  in  2  00 ctrl (branch/jump, no rd write), 01 reg write, 10 load, 11 store
- i_riscv_trace_compressed  in  1  1 = 16-bit instruction
- i_riscv_trace_funct3  in  3  access size for load/store
- i_riscv_trace_rd  in  5  destination register index
- i_riscv_trace_pc  in  64  instruction PC
- i_riscv_trace_instr  in  32  instruction bits; [15:0] used when compressed
- i_riscv_trace_rdval  in  64  value written to rd
- i_riscv_trace_memaddr  in  64  load/store address
- i_riscv_trace_store  in  64  store data
- o_riscv_trace_byte  out  8  stream byte
- o_riscv_trace_byte_valid  out  1  byte valid
- i_riscv_trace_byte_ready  in  1  sink accepts byte
- o_riscv_trace_full  out  1  FIFO full
- o_riscv_trace_drops  out  DROP_W  records lost to overflow, saturating
- o_riscv_trace_busy  out  1  packet in flight or FIFO non-empty

Behaviour:
- Reset (async, while rst_n=0):
  - FIFO empty; FSM in IDLE.
  - byte_valid=0, byte=0, full=0, drops=0, busy=0.
  - Reset mid-packet aborts the packet immediately; no partial resume.
- Capture:
  - On a rising edge with valid=1 and full=0, the record is pushed.
  - valid=1 with full=1: record dropped, drops+1, saturating at all-ones.
  - A pop in the same cycle does not rescue a push while full.
- Packet fields, in order; each multi-byte field is sent LSB first:
  - HDR: 1 byte = {kind[1:0], compressed, funct3[2:0], 2'b00}.
  - RD: 1 byte = {3'b000, rd}; always sent.
  - PC: 8 bytes.
  - INSTR: 2 bytes if compressed, else 4.
  - VAL: 8 bytes; only for kind 01, or kind 10 with rd≠0.
  - ADDR: 8 bytes; only for kind 10/11.
  - SDATA: 1/2/4/8 bytes per funct3[1:0]; kind 11 only.
- FSM states: IDLE, HDR, RD, PC, INSTR, VAL, ADDR, SDATA.
  - A 3-bit byte counter indexes the bytes within a field.
  - Advance only on valid & ready. Absent fields are skipped; no bubble bytes are emitted.
  - IDLE→HDR on the edge where the FIFO is non-empty.
  - After the last byte of a packet, pop the FIFO. Go to HDR if a further entry exists, else IDLE (back-to-back packets, no idle cycle).
- Latency: record captured at edge E0 → byte_valid=1 with HDR after edge E1.
- Stream rule: while byte_valid=1 and ready=0, byte and valid hold stable. valid never drops mid-packet.
- Output decode:
  - byte is a registered-state mux over the FIFO head; the head is stable until popped.
  - byte_valid = (state≠IDLE).
- Packet lengths:
  - ctrl: 14 bytes (12 if compressed).
  - regwrite: 22 / 20.
  - load rd≠0: 30 / 28; load rd=0: 22 / 20.
  - store: 22 + size (compressed: 20 + size).
- Status: full = (count==FIFO_DEPTH). busy = (state≠IDLE) | (count≠0).

Decomposition:
- Package riscv_trace_pkg holds:
  - kind enum (TRACE_CTRL, TRACE_REG, TRACE_LOAD, TRACE_STORE)
  - FSM state enum
  - packed trace record struct
  - field length constants (PC_BYTES=8, VAL_BYTES=8, ADDR_BYTES=8)
- Sub-module riscv_trace_fifo:
  - synchronous FIFO of records: push/pop/full/empty/count
  - same clock and async active-low reset

Test Plan:
- Reg-write record, ready=1:
  - Stimulus: pc=0x80000000, instr=0x00500093, rd=1, rdval=5.
  - Response: 22 bytes: 0x40, 0x01, 00 00 00 80 00 00 00 00, 93 00 50 00, 05 00 00 00 00 00 00 00; HDR valid one cycle after capture edge.
- Compressed store doubleword:
  - Stimulus: c=0xe406, addr=0x80001ff8, data=0x0123456789abcdef.
  - Response: 28 bytes; HDR=0xEC; SDATA = ef cd ab 89 67 45 23 01.
- Load with rd=0, funct3=010:
  - Response: 22 bytes, no VAL field, HDR=0x88.
- Backpressure:
  - Stimulus: toggle ready 1/0 every cycle.
  - Response: byte stream identical to ready=1 case; byte stable while ready=0.
- Overflow:
  - Stimulus: ready=0, push 6 records with FIFO_DEPTH=4.
  - Response: full=1 after 4th push, drops=2; release ready → 4 packets back-to-back, no idle cycle between.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 at byte 5 of a packet.
  - Response: byte_valid=0 asynchronously, drops=0, busy=0; next record after reset starts with HDR.
